rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Write-back arbiter and sequencer for the 32x32 register file's single write port (WE3/a3/wd3). It accepts write-back requests from two producers, the ALU path (req0) and the load/store unit (req1), over valid/ready handshakes. Each cycle it grants at most one producer using round-robin priority and drives a registered write command into the register file. It suppresses writes to x0, exposes a read-bypass for the in-flight write, and counts contention cycles.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
CNT_W, 16, width of the saturating contention counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
wb_en  in  1  pipeline enable; 0 = no grants this cycle
req0_valid  in  1  ALU write-back request
req0_addr  in  ADDR_W  ALU destination register
req0_data  in  DATA_W  ALU result
req0_ready  out  1  ALU request accepted this cycle
req1_valid  in  1  LSU write-back request
req1_addr  in  ADDR_W  LSU destination register
req1_data  in  DATA_W  load data
req1_ready  out  1  LSU request accepted this cycle
wb_we  out  1  register-file write enable (to WE3)
wb_addr  out  ADDR_W  register-file write address (to a3)
wb_data  out  DATA_W  register-file write data (to wd3)
rd_a1  in  ADDR_W  register-file read address 1 (mirror of a1)
rd_a2  in  ADDR_W  register-file read address 2 (mirror of a2)
byp1_hit  out  1  rd_a1 matches the in-flight write
byp2_hit  out  1  rd_a2 matches the in-flight write
byp_data  out  DATA_W  bypass value (equals wb_data)
conflict_cnt  out  CNT_W  cycles in which both requests were valid while wb_en=1

Behaviour:
- Reset (reset=0, asynchronous):
  - wb_we=0, wb_addr=0, wb_data=0, conflict_cnt=0, rr_ptr=0.
  - req0_ready=0 and req1_ready=0 while reset is low.
  - A transfer in progress when reset asserts is lost; producers re-present their request after reset.
- Grant logic (combinational, from the current valids, wb_en and rr_ptr):
  - wb_en=0: no grant; both ready outputs = 0.
  - Exactly one request valid: that requester is granted.
  - Both valid: the requester indexed by rr_ptr is granted.
  - reqN_ready = grantN. A ready is never asserted without its valid.
- Transfer:
  - A transfer occurs when valid & ready.
  - Producers hold valid, addr and data stable until accepted.
  - Neither producer may drop valid before acceptance.
- rr_ptr update at the clock edge:
  - On any grant, rr_ptr becomes the index of the non-granted requester.
  - Without a grant, rr_ptr holds.
  - Consequence: under continuous contention the grants alternate, so maximum wait is 1 cycle.
- Output register (latency 1 from acceptance to wb_we):
  - On a grant: wb_addr and wb_data are loaded from the granted request; wb_we = (granted addr != 0).
  - x0 writes are accepted (ready=1) but produce wb_we=0.
  - No grant: wb_we=0; wb_addr and wb_data hold their previous values.
  - wb_we is high for exactly one cycle per accepted non-x0 request.
- Bypass (combinational from the output register):
  - bypN_hit = wb_we & (wb_addr == rd_aN) & (rd_aN != 0).
  - byp_data = wb_data.
  - This covers the cycle in which the register file has not yet captured the write.
- conflict_cnt:
  - Increments by 1 each cycle where req0_valid & req1_valid & wb_en.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Same destination address from both requesters in one cycle: no special handling. The granted request writes first and the other writes on a later grant, so the later grant wins in the register file.
- wb_en deasserted while both requesters are valid: no grant, no rr_ptr change and no conflict count. Requests stay pending.

Test Plan:
1. Reset, then req0 valid with addr=5, data=0xDEADBEEF, wb_en=1 -> req0_ready=1 in cycle 0; next cycle wb_we=1, wb_addr=5, wb_data=0xDEADBEEF; following cycle wb_we=0.
2. Both valid for 4 cycles (req0 addr 1..4, req1 addr 11..14, each producer advancing only after acceptance) -> grants in order req0,req1,req0,req1; wb_addr sequence 1,11,2,12; conflict_cnt=4.
3. req1 valid with addr=0, data=0x1234 -> req1_ready=1, next cycle wb_we=0, byp1_hit=0 even with rd_a1=0.
4. req0 addr=7, data=0x55 accepted; next cycle rd_a1=7, rd_a2=8 -> byp1_hit=1, byp_data=0x55, byp2_hit=0.
5. Both valid with wb_en=0 for 3 cycles, then wb_en=1 -> no ready and wb_we=0 during the stall, conflict_cnt unchanged; the first grant goes to the current rr_ptr side.
6. Assert reset in the cycle after req0 (addr=9) is accepted -> wb_we, wb_addr and wb_data go to 0 immediately without waiting for a clock edge; after release, rr_ptr=0 and conflict_cnt=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter for the register file's single
// write port. Two producers (ALU = req0, LSU = req1) hand over write-backs via
// valid/ready; the granted request is registered onto wb_we/wb_addr/wb_data
// one cycle later. Writes to x0 are accepted but never raise wb_we. A
// combinational bypass exposes the in-flight write, and a saturating counter
// records cycles in which both producers contended while the pipeline was enabled.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rd_a1,
  input  logic [ADDR_W-1:0] rd_a2,
  output logic              byp1_hit,
  output logic              byp2_hit,
  output logic [DATA_W-1:0] byp_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Which requester wins the next contended cycle.
  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_sel_e;

  rr_sel_e             rr_ptr;
  logic                grant0;
  logic                grant1;
  logic                grant_any;
  logic                contend;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Grant decode: a lone valid wins outright, a tie is broken by rr_ptr.
  // Readies are forced low while reset is held so no handshake completes then.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    sel_addr = req0_addr;
    sel_data = req0_data;
    if (reset && wb_en) begin
      if (req0_valid && req1_valid) begin
        grant0 = (rr_ptr == RR_REQ0);
        grant1 = (rr_ptr == RR_REQ1);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    if (grant1) begin
      sel_addr = req1_addr;
      sel_data = req1_data;
    end
  end

  assign grant_any  = grant0 | grant1;
  assign contend    = req0_valid & req1_valid & wb_en;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Round-robin pointer: after a grant, favour the requester that lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= RR_REQ0;
    end else if (grant0) begin
      rr_ptr <= RR_REQ1;
    end else if (grant1) begin
      rr_ptr <= RR_REQ0;
    end
  end

  // Write command register: load on grant, pulse wb_we for non-x0 targets,
  // keep address/data stable when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (grant_any) begin
      wb_we   <= (sel_addr != '0);
      wb_addr <= sel_addr;
      wb_data <= sel_data;
    end else begin
      wb_we   <= 1'b0;
    end
  end

  // Contention counter, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (contend && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  // Bypass of the write the register file has not captured yet; x0 never hits.
  assign byp1_hit = wb_we & (wb_addr == rd_a1) & (rd_a1 != '0);
  assign byp2_hit = wb_we & (wb_addr == rd_a2) & (rd_a2 != '0);
  assign byp_data = wb_data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: stimulus pushes hand-computed write
// commands, a negedge monitor pops and compares whenever wb_we is presented.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_en;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rd_a1, rd_a2;
  logic          byp1_hit, byp2_hit;
  logic [DW-1:0] byp_data;
  logic [CW-1:0] conflict_cnt;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .wb_en(wb_en),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .byp1_hit(byp1_hit), .byp2_hit(byp2_hit),
    .byp_data(byp_data), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b1 && wb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wb_unexpected: got write addr %0d data 0x%0h expected no write at %0t",
                 wb_addr, wb_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("wb_addr", 32'(wb_addr), 32'(e.addr));
        check("wb_data", wb_data, e.data);
      end
    end
  end

  // One arbitration cycle: drive, check readies at negedge, record expected write.
  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic en, input logic g0, input logic g1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    wb_en = en;
    @(negedge clk);
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    if (g0 && a0 != '0) exp_q.push_back({a0, d0});
    if (g1 && a1 != '0) exp_q.push_back({a1, d1});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned i0;
    int unsigned i1;
    logic g;
    reset = 1'b0; wb_en = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1;
    req1_valid = 1'b0; req1_addr = '0;   req1_data = '0;
    rd_a1 = '0; rd_a2 = '0;
    #1;
    // reset state, readies gated even with a valid request
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_conflict", 32'(conflict_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // 1: single ALU write, one-cycle wb_we pulse
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    idle();
    check("t1_we_low", 32'(wb_we), 32'd0);

    // 2: continuous contention from rr_ptr=0, grants alternate
    reset_pulse();
    i0 = 1; i1 = 11;
    for (int k = 0; k < 8; k++) begin
      g = (k % 2 == 0);
      drive(1'b1, AW'(i0), 32'hA5A5_0000 | i0, 1'b1, AW'(i1), 32'hA5A5_0000 | i1,
            1'b1, g, !g);
      if (g) i0++; else i1++;
      if (k == 3) check("t2_conflict4", 32'(conflict_cnt), 32'd4);
    end
    check("t2_conflict8", 32'(conflict_cnt), 32'd8);

    // 3: x0 write accepted, no write enable, no bypass hit
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b0, 1'b1);
    rd_a1 = 5'd0; #1;
    check("t3_we", 32'(wb_we), 32'd0);
    check("t3_byp1", 32'(byp1_hit), 32'd0);
    check("t3_addr", 32'(wb_addr), 32'd0);
    check("t3_data", wb_data, 32'h1234);

    // 4: bypass of in-flight write
    drive(1'b1, 5'd7, 32'h55, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    rd_a1 = 5'd7; rd_a2 = 5'd8; #1;
    check("t4_byp1", 32'(byp1_hit), 32'd1);
    check("t4_byp_data", byp_data, 32'h55);
    check("t4_byp2", 32'(byp2_hit), 32'd0);
    rd_a2 = 5'd7; #1;
    check("t4_byp2_match", 32'(byp2_hit), 32'd1);

    // 5: stall with both valid, then first grant follows rr_ptr (req1)
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd20, 32'h2020, 1'b1, 5'd21, 32'h2121, 1'b0, 1'b0, 1'b0);
      check("t5_stall_we", 32'(wb_we), 32'd0);
      check("t5_stall_cnt", 32'(conflict_cnt), 32'd8);
    end
    drive(1'b1, 5'd20, 32'h2020, 1'b1, 5'd21, 32'h2121, 1'b1, 1'b0, 1'b1);
    check("t5_cnt9", 32'(conflict_cnt), 32'd9);
    drive(1'b1, 5'd20, 32'h2020, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    check("t5_cnt_hold", 32'(conflict_cnt), 32'd9);

    // 6: asynchronous reset while a write is in flight
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h9999; wb_en = 1'b1;
    @(negedge clk);
    check("t6_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    check("t6_we_before", 32'(wb_we), 32'd1);
    reset = 1'b0; #1;
    check("t6_we_async", 32'(wb_we), 32'd0);
    check("t6_addr_async", 32'(wb_addr), 32'd0);
    check("t6_data_async", wb_data, 32'd0);
    check("t6_ready_rst", 32'(req0_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    check("t6_cnt_clr", 32'(conflict_cnt), 32'd0);
    drive(1'b1, 5'd2, 32'h0202, 1'b1, 5'd3, 32'h0303, 1'b1, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h0303, 1'b1, 1'b0, 1'b1);
    check("t6_cnt1", 32'(conflict_cnt), 32'd1);

    // 7: counter saturation (CNT_W=4): 1 + 20 contended cycles caps at 15
    i0 = 1; i1 = 17;
    for (int k = 0; k < 20; k++) begin
      g = (k % 2 == 0);
      drive(1'b1, AW'(i0), 32'h7700_0000 | i0, 1'b1, AW'(i1), 32'h7700_0000 | i1,
            1'b1, g, !g);
      if (g) i0++; else i1++;
      if (k == 13) check("t7_cnt15", 32'(conflict_cnt), 32'd15);
    end
    check("t7_cnt_sat", 32'(conflict_cnt), 32'd15);

    idle();
    idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
